// File: rtl/ycr1_mtimer_pkg.sv
// Shared definitions for the multi-channel machine timer: bus encodings, register map,
// channel configuration struct and address-decode enum.
package ycr1_mtimer_pkg;

  localparam logic       YCR1_MEM_CMD_RD       = 1'b0;
  localparam logic       YCR1_MEM_CMD_WR       = 1'b1;

  localparam logic [1:0] YCR1_MEM_WIDTH_BYTE   = 2'b00;
  localparam logic [1:0] YCR1_MEM_WIDTH_HWORD  = 2'b01;
  localparam logic [1:0] YCR1_MEM_WIDTH_WORD   = 2'b10;

  localparam logic [1:0] YCR1_MEM_RESP_NOTRDY  = 2'b00;
  localparam logic [1:0] YCR1_MEM_RESP_RDY_OK  = 2'b01;
  localparam logic [1:0] YCR1_MEM_RESP_RDY_ER  = 2'b10;

  // Global register offsets (below the channel window)
  localparam logic [4:0] REG_CONTROL    = 5'h00;
  localparam logic [4:0] REG_DIVIDER    = 5'h04;
  localparam logic [4:0] REG_MTIMELO    = 5'h08;
  localparam logic [4:0] REG_MTIMEHI    = 5'h0C;
  localparam logic [4:0] REG_IRQ_STATUS = 5'h10;
  localparam logic [4:0] REG_IRQ_ENABLE = 5'h14;

  // Per-channel word index within each 16-byte channel window starting at 0x20
  localparam logic [1:0] CH_CMPLO  = 2'd0;
  localparam logic [1:0] CH_CMPHI  = 2'd1;
  localparam logic [1:0] CH_PERIOD = 2'd2;
  localparam logic [1:0] CH_CTRL   = 2'd3;

  localparam int CHCTRL_EN_BIT  = 0;
  localparam int CHCTRL_PER_BIT = 1;

  typedef struct packed {
    logic [63:0] cmp;
    logic [31:0] period;
    logic        en;
    logic        periodic;
  } ch_cfg_t;

  typedef enum logic [3:0] {
    DEC_CTRL,
    DEC_DIV,
    DEC_MTLO,
    DEC_MTHI,
    DEC_STAT,
    DEC_IEN,
    DEC_CMPLO,
    DEC_CMPHI,
    DEC_PERIOD,
    DEC_CHCTRL,
    DEC_ERR
  } dec_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_RESP
  } bus_st_e;

  function automatic dec_e decode_glb(input logic [4:0] off);
    case (off)
      REG_CONTROL:    return DEC_CTRL;
      REG_DIVIDER:    return DEC_DIV;
      REG_MTIMELO:    return DEC_MTLO;
      REG_MTIMEHI:    return DEC_MTHI;
      REG_IRQ_STATUS: return DEC_STAT;
      REG_IRQ_ENABLE: return DEC_IEN;
      default:        return DEC_ERR;
    endcase
  endfunction

  function automatic dec_e decode_ch(input logic [1:0] word);
    case (word)
      CH_CMPLO:  return DEC_CMPLO;
      CH_CMPHI:  return DEC_CMPHI;
      CH_PERIOD: return DEC_PERIOD;
      default:   return DEC_CHCTRL;
    endcase
  endfunction

endpackage

// File: rtl/ycr1_mtimer_chan.sv
// One timer compare channel: CMP/PERIOD/CHCTRL registers, registered comparator,
// periodic auto-advance and the channel's pending status bit.
module ycr1_mtimer_chan
  import ycr1_mtimer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] i_mtime,
  input  logic [31:0] i_wdata,
  input  logic        i_wr_cmplo,
  input  logic        i_wr_cmphi,
  input  logic        i_wr_period,
  input  logic        i_wr_ctrl,
  input  logic        i_w1c,
  output ch_cfg_t     o_cfg,
  output logic        o_status
);

  logic [63:0] r_cmp;
  logic [31:0] r_period;
  logic        r_en;
  logic        r_periodic;
  logic        r_match;
  logic        r_status;

  logic        w_adv;
  logic        w_cmp_wr;

  assign w_adv    = r_match & r_en & r_periodic;
  assign w_cmp_wr = i_wr_cmplo | i_wr_cmphi;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmp      <= '1;
      r_period   <= '0;
      r_en       <= 1'b0;
      r_periodic <= 1'b0;
    end else begin
      if (i_wr_cmplo)
        r_cmp[31:0] <= i_wdata;
      else if (i_wr_cmphi)
        r_cmp[63:32] <= i_wdata;
      else if (w_adv)
        r_cmp <= r_cmp + {32'b0, r_period};
      if (i_wr_period)
        r_period <= i_wdata;
      if (i_wr_ctrl) begin
        r_en       <= i_wdata[CHCTRL_EN_BIT];
        r_periodic <= i_wdata[CHCTRL_PER_BIT];
      end
    end
  end

  // The compare result is one cycle stale, so it is discarded whenever CMP moves
  // (SW write or advance); a zero period keeps CMP put and re-matches every cycle.
  always_ff @(posedge clk) begin
    if (rst)
      r_match <= 1'b0;
    else if (w_cmp_wr || i_wr_ctrl || (w_adv && (r_period != 32'd0)))
      r_match <= 1'b0;
    else
      r_match <= r_en && (i_mtime >= r_cmp);
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_status <= 1'b0;
    else if (i_wr_ctrl && !i_wdata[CHCTRL_EN_BIT])
      r_status <= 1'b0;
    else if (r_periodic)
      r_status <= w_adv | (r_status & ~i_w1c);
    else
      r_status <= 1'b0;
  end

  assign o_status = r_periodic ? r_status : r_match;

  always_comb begin
    o_cfg          = '0;
    o_cfg.cmp      = r_cmp;
    o_cfg.period   = r_period;
    o_cfg.en       = r_en;
    o_cfg.periodic = r_periodic;
  end

endmodule

// File: rtl/ycr1_mtimer_mc.sv
// Multi-channel machine timer on the dmem bus: prescaled 64-bit mtime, NUM_CH compare channels.
// Build option YCR1_MTIMER_SNAPSHOT_EN adds a tear-free MTIMEHI shadow latched by MTIMELO reads.
module ycr1_mtimer_mc
  import ycr1_mtimer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_dmem_req,
  input  logic              i_dmem_cmd,
  input  logic [1:0]        i_dmem_width,
  input  logic [ADDR_W-1:0] i_dmem_addr,
  input  logic [31:0]       i_dmem_wdata,
  output logic              o_dmem_req_ack,
  output logic [31:0]       o_dmem_rdata,
  output logic [1:0]        o_dmem_resp,
  output logic [63:0]       o_timer_val,
  output logic              o_timer_irq,
  output logic [NUM_CH-1:0] o_timer_irq_vec
);

  localparam int HW = ADDR_W - 4;

  bus_st_e           r_state;
  bus_st_e           w_state_next;
  logic              r_cmd;
  logic [1:0]        r_width;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              r_en;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_pcnt;
  logic [31:0]       r_mt_lo;
  logic [31:0]       r_mt_hi;
  logic [NUM_CH-1:0] r_ien;
  logic              r_irq;
  logic [NUM_CH-1:0] r_irq_vec;

  dec_e              w_dec;
  logic [HW-1:0]     w_hi;
  logic [HW-1:0]     w_ch_idx;
  logic [NUM_CH-1:0] w_ch_sel;
  logic              w_wr;
  logic              w_rd;
  logic              w_tick;
  logic              w_mt_wr;
  logic [31:0]       w_rdata;
  logic [31:0]       w_mthi_rd;
  logic [NUM_CH-1:0] w_status;
  ch_cfg_t           w_cfg [NUM_CH];
  ch_cfg_t           w_sel_cfg;

  // Bus FSM: a request is accepted whenever ack is not being driven this cycle
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_dmem_req) w_state_next = ST_ACK;
      ST_ACK:  w_state_next = ST_RESP;
      ST_RESP: w_state_next = i_dmem_req ? ST_ACK : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_dmem_req_ack = (r_state == ST_ACK);
    o_dmem_resp    = YCR1_MEM_RESP_NOTRDY;
    o_dmem_rdata   = '0;
    if (r_state == ST_RESP) begin
      o_dmem_resp = (w_dec == DEC_ERR) ? YCR1_MEM_RESP_RDY_ER : YCR1_MEM_RESP_RDY_OK;
      if (w_rd)
        o_dmem_rdata = w_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd   <= YCR1_MEM_CMD_RD;
      r_width <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (i_dmem_req && (r_state != ST_ACK)) begin
      r_cmd   <= i_dmem_cmd;
      r_width <= i_dmem_width;
      r_addr  <= i_dmem_addr;
      r_wdata <= i_dmem_wdata;
    end
  end

  assign w_hi     = r_addr[ADDR_W-1:4];
  assign w_ch_idx = w_hi - HW'(2);

  always_comb begin
    w_dec = DEC_ERR;
    if ((r_width == YCR1_MEM_WIDTH_WORD) && (r_addr[1:0] == 2'b00)) begin
      if (w_hi < HW'(2))
        w_dec = decode_glb(r_addr[4:0]);
      else if (w_ch_idx < HW'(NUM_CH))
        w_dec = decode_ch(r_addr[3:2]);
    end
  end

  assign w_wr = (r_state == ST_RESP) && (r_cmd == YCR1_MEM_CMD_WR) && (w_dec != DEC_ERR);
  assign w_rd = (r_state == ST_RESP) && (r_cmd == YCR1_MEM_CMD_RD) && (w_dec != DEC_ERR);

  // Prescaler: tick on the cycle the down-counter sits at zero
  assign w_tick = r_en && (r_pcnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_en   <= 1'b1;
      r_div  <= '0;
      r_pcnt <= '0;
    end else begin
      if (w_wr && (w_dec == DEC_CTRL))
        r_en <= r_wdata[0];
      if (w_wr && (w_dec == DEC_DIV)) begin
        r_div  <= r_wdata[DIV_W-1:0];
        r_pcnt <= r_wdata[DIV_W-1:0];
      end else if (r_en) begin
        r_pcnt <= (r_pcnt == '0) ? r_div : r_pcnt - 1'b1;
      end
    end
  end

  // mtime as two 32-bit halves; carry into hi comes from the registered lo value
  assign w_mt_wr = w_wr && ((w_dec == DEC_MTLO) || (w_dec == DEC_MTHI));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mt_lo <= '0;
      r_mt_hi <= '0;
    end else if (w_mt_wr) begin
      if (w_dec == DEC_MTLO)
        r_mt_lo <= r_wdata;
      if (w_dec == DEC_MTHI)
        r_mt_hi <= r_wdata;
    end else if (w_tick) begin
      r_mt_lo <= r_mt_lo + 32'd1;
      if (r_mt_lo == 32'hFFFF_FFFF)
        r_mt_hi <= r_mt_hi + 32'd1;
    end
  end

  assign o_timer_val = {r_mt_hi, r_mt_lo};

`ifdef YCR1_MTIMER_SNAPSHOT_EN
  logic [31:0] r_shadow;
  logic        r_shadow_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow     <= '0;
      r_shadow_vld <= 1'b0;
    end else if (w_mt_wr) begin
      r_shadow_vld <= 1'b0;
    end else if (w_rd && (w_dec == DEC_MTLO)) begin
      r_shadow     <= r_mt_hi;
      r_shadow_vld <= 1'b1;
    end else if (w_rd && (w_dec == DEC_MTHI)) begin
      r_shadow_vld <= 1'b0;
    end
  end

  assign w_mthi_rd = r_shadow_vld ? r_shadow : r_mt_hi;
`else
  assign w_mthi_rd = r_mt_hi;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ien     <= '0;
      r_irq     <= 1'b0;
      r_irq_vec <= '0;
    end else begin
      if (w_wr && (w_dec == DEC_IEN))
        r_ien <= r_wdata[NUM_CH-1:0];
      r_irq_vec <= w_status & r_ien;
      r_irq     <= |(w_status & r_ien);
    end
  end

  assign o_timer_irq     = r_irq;
  assign o_timer_irq_vec = r_irq_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_ch_sel[gi] = (w_hi >= HW'(2)) && (w_ch_idx == HW'(gi));

      ycr1_mtimer_chan u_chan (
        .clk         (clk),
        .rst         (rst),
        .i_mtime     ({r_mt_hi, r_mt_lo}),
        .i_wdata     (r_wdata),
        .i_wr_cmplo  (w_wr && (w_dec == DEC_CMPLO)  && w_ch_sel[gi]),
        .i_wr_cmphi  (w_wr && (w_dec == DEC_CMPHI)  && w_ch_sel[gi]),
        .i_wr_period (w_wr && (w_dec == DEC_PERIOD) && w_ch_sel[gi]),
        .i_wr_ctrl   (w_wr && (w_dec == DEC_CHCTRL) && w_ch_sel[gi]),
        .i_w1c       (w_wr && (w_dec == DEC_STAT)   && r_wdata[gi]),
        .o_cfg       (w_cfg[gi]),
        .o_status    (w_status[gi])
      );
    end
  endgenerate

  always_comb begin
    w_sel_cfg = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (w_ch_sel[k])
        w_sel_cfg = w_cfg[k];
  end

  always_comb begin
    w_rdata = '0;
    case (w_dec)
      DEC_CTRL:   w_rdata = {31'b0, r_en};
      DEC_DIV:    w_rdata = 32'(r_div);
      DEC_MTLO:   w_rdata = r_mt_lo;
      DEC_MTHI:   w_rdata = w_mthi_rd;
      DEC_STAT:   w_rdata = 32'(w_status);
      DEC_IEN:    w_rdata = 32'(r_ien);
      DEC_CMPLO:  w_rdata = w_sel_cfg.cmp[31:0];
      DEC_CMPHI:  w_rdata = w_sel_cfg.cmp[63:32];
      DEC_PERIOD: w_rdata = w_sel_cfg.period;
      DEC_CHCTRL: w_rdata = {30'b0, w_sel_cfg.periodic, w_sel_cfg.en};
      default:    w_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_ycr1_mtimer_mc.sv
// Directed self-checking bench for ycr1_mtimer_mc (default NUM_CH=4); honours YCR1_MTIMER_SNAPSHOT_EN.
module tb_ycr1_mtimer_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dmem_req = 1'b0;
  logic        dmem_cmd = 1'b0;
  logic [1:0]  dmem_width = 2'b10;
  logic [7:0]  dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic        dmem_req_ack;
  logic [31:0] dmem_rdata;
  logic [1:0]  dmem_resp;
  logic [63:0] timer_val;
  logic        timer_irq;
  logic [3:0]  timer_irq_vec;

  int tests = 0;
  int fails = 0;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_WORD = 2'b10;
  localparam logic [1:0] R_NOTRDY = 2'b00;
  localparam logic [1:0] R_OK = 2'b01;
  localparam logic [1:0] R_ER = 2'b10;

  always #5 clk = ~clk;

  ycr1_mtimer_mc dut (
    .clk             (clk),
    .rst             (rst),
    .i_dmem_req      (dmem_req),
    .i_dmem_cmd      (dmem_cmd),
    .i_dmem_width    (dmem_width),
    .i_dmem_addr     (dmem_addr),
    .i_dmem_wdata    (dmem_wdata),
    .o_dmem_req_ack  (dmem_req_ack),
    .o_dmem_rdata    (dmem_rdata),
    .o_dmem_resp     (dmem_resp),
    .o_timer_val     (timer_val),
    .o_timer_irq     (timer_irq),
    .o_timer_irq_vec (timer_irq_vec)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Returns at the falling edge of the response cycle; writes land on the next rising edge.
  task automatic bus_xfer(input logic cmd, input logic [1:0] width, input logic [7:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata, output logic [1:0] resp);
    bit got;
    got   = 1'b0;
    rdata = '0;
    resp  = 2'b11;
    @(negedge clk);
    dmem_req   = 1'b1;
    dmem_cmd   = cmd;
    dmem_width = width;
    dmem_addr  = addr;
    dmem_wdata = wdata;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (dmem_req_ack === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    dmem_req = 1'b0;
    if (!got) begin
      tests++; fails++;
      $display("FAIL bus_ack addr=%02h: ack not seen within 4 cycles, required 1", addr);
    end else begin
      @(posedge clk);
      @(negedge clk);
      resp  = dmem_resp;
      rdata = dmem_rdata;
    end
    $display("[TB] bus %s addr=%02h wdata=%08h -> resp=%0d rdata=%08h", cmd ? "WR" : "RD", addr, wdata, resp, rdata);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    logic [31:0] rd_d;
    logic [1:0]  rs;
    bus_xfer(1'b1, W_WORD, addr, data, rd_d, rs);
  endtask

  task automatic rd(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] rs);
    bus_xfer(1'b0, W_WORD, addr, 32'h0, data, rs);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(3);
    tests++;
    if (timer_val !== 64'd0 || dmem_resp !== R_NOTRDY || dmem_req_ack !== 1'b0 ||
        timer_irq !== 1'b0 || timer_irq_vec !== 4'd0 || dmem_rdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: mtime=%h resp=%0d ack=%b irq=%b vec=%b rdata=%h, required all 0",
               timer_val, dmem_resp, dmem_req_ack, timer_irq, timer_irq_vec, dmem_rdata);
    end
    rst = 1'b0;
    step(1);
    tests++;
    if (timer_val !== 64'd1) begin
      fails++; $display("FAIL reset_first_tick: mtime=%0d, required 1", timer_val);
    end
    step(1);
    tests++;
    if (timer_val !== 64'd2) begin
      fails++; $display("FAIL reset_div0_rate: mtime=%0d, required 2", timer_val);
    end
  endtask

  task automatic test_prescaler;
    logic [63:0] v0;
    logic [31:0] d;
    logic [1:0]  rs;
    wr(8'h04, 32'd3);
    step(1);
    v0 = timer_val;
    step(3);
    tests++;
    if (timer_val !== v0) begin
      fails++; $display("FAIL div_hold: mtime=%0d, required %0d", timer_val, v0);
    end
    step(1);
    tests++;
    if (timer_val !== v0 + 64'd1) begin
      fails++; $display("FAIL div_first_tick: mtime=%0d, required %0d", timer_val, v0 + 64'd1);
    end
    step(4);
    tests++;
    if (timer_val !== v0 + 64'd2) begin
      fails++; $display("FAIL div_period: mtime=%0d, required %0d", timer_val, v0 + 64'd2);
    end
    rd(8'h04, d, rs);
    tests++;
    if (d !== 32'd3 || rs !== R_OK) begin
      fails++; $display("FAIL div_readback: data=%0d resp=%0d, required 3 resp 1", d, rs);
    end
  endtask

  task automatic test_carry;
    logic [63:0] v;
    wr(8'h00, 32'd0);
    wr(8'h04, 32'd0);
    wr(8'h08, 32'hFFFF_FFFF);
    wr(8'h0C, 32'd0);
    v = timer_val;
    step(5);
    tests++;
    if (timer_val !== v || v !== 64'h0000_0000_FFFF_FFFF) begin
      fails++; $display("FAIL freeze: mtime=%h (was %h), required 00000000ffffffff", timer_val, v);
    end
    wr(8'h00, 32'd1);
    step(1);
    tests++;
    if (timer_val !== 64'h0000_0000_FFFF_FFFF) begin
      fails++; $display("FAIL carry_pre: mtime=%h, required 00000000ffffffff", timer_val);
    end
    step(1);
    tests++;
    if (timer_val !== 64'h0000_0001_0000_0000) begin
      fails++; $display("FAIL carry: mtime=%h, required 0000000100000000", timer_val);
    end
    wr(8'h00, 32'd0);
    wr(8'h08, 32'hFFFF_FFFF);
    wr(8'h0C, 32'hFFFF_FFFF);
    wr(8'h00, 32'd1);
    step(2);
    tests++;
    if (timer_val !== 64'd0) begin
      fails++; $display("FAIL wrap64: mtime=%h, required 0", timer_val);
    end
  endtask

  task automatic test_periodic;
    logic [31:0] d;
    logic [1:0]  rs;
    bit          seen;
    wr(8'h00, 32'd0);
    wr(8'h04, 32'd3);
    wr(8'h08, 32'd90);
    wr(8'h0C, 32'd0);
    wr(8'h20, 32'd100);
    wr(8'h24, 32'd0);
    wr(8'h28, 32'd50);
    wr(8'h14, 32'd1);
    wr(8'h2C, 32'd3);
    wr(8'h00, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (timer_irq_vec[0] === 1'b1) begin seen = 1'b1; break; end
    end
    tests++;
    if (!seen || timer_val !== 64'd100 || timer_irq !== 1'b1) begin
      fails++; $display("FAIL per_first_set: seen=%b mtime=%0d irq=%b, required seen at mtime 100 irq 1", seen, timer_val, timer_irq);
    end
    rd(8'h10, d, rs);
    tests++;
    if (d[0] !== 1'b1 || rs !== R_OK) begin
      fails++; $display("FAIL per_status_read: status=%h resp=%0d, required bit0=1 resp 1", d, rs);
    end
    wr(8'h10, 32'd1);
    rd(8'h10, d, rs);
    tests++;
    if (d[0] !== 1'b0 || timer_irq !== 1'b0) begin
      fails++; $display("FAIL per_w1c: status=%h irq=%b, required bit0=0 irq 0", d, timer_irq);
    end
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (timer_irq_vec[0] === 1'b1) begin seen = 1'b1; break; end
    end
    tests++;
    if (!seen || timer_val !== 64'd150) begin
      fails++; $display("FAIL per_reset_at_150: seen=%b mtime=%0d, required seen at mtime 150", seen, timer_val);
    end
    rd(8'h20, d, rs);
    tests++;
    if (d !== 32'd200) begin
      fails++; $display("FAIL per_cmp_advance: cmplo=%0d, required 200", d);
    end
  endtask

  task automatic test_level;
    logic [31:0] d;
    logic [1:0]  rs;
    wr(8'h14, 32'd0);
    wr(8'h2C, 32'd0);
    wr(8'h30, 32'd10);
    wr(8'h34, 32'd0);
    wr(8'h3C, 32'd1);
    rd(8'h10, d, rs);
    tests++;
    if (d[1] !== 1'b1 || d[0] !== 1'b0) begin
      fails++; $display("FAIL lvl_match: status=%h, required bit1=1 bit0=0", d);
    end
    tests++;
    if (timer_irq !== 1'b0) begin
      fails++; $display("FAIL lvl_irq_masked: irq=%b, required 0", timer_irq);
    end
    wr(8'h10, 32'd2);
    rd(8'h10, d, rs);
    tests++;
    if (d[1] !== 1'b1) begin
      fails++; $display("FAIL lvl_w1c_ignored: status=%h, required bit1=1", d);
    end
    wr(8'h30, 32'd1000);
    rd(8'h10, d, rs);
    tests++;
    if (d[1] !== 1'b0) begin
      fails++; $display("FAIL lvl_cmp_rewrite: status=%h, required bit1=0", d);
    end
  endtask

  task automatic test_set_wins;
    logic [31:0] d;
    logic [1:0]  rs;
    wr(8'h40, 32'd0);
    wr(8'h44, 32'd0);
    wr(8'h48, 32'd0);
    wr(8'h4C, 32'd3);
    wr(8'h10, 32'd4);
    rd(8'h10, d, rs);
    tests++;
    if (d[2] !== 1'b1) begin
      fails++; $display("FAIL set_wins_w1c: status=%h, required bit2=1", d);
    end
    wr(8'h4C, 32'd0);
    rd(8'h10, d, rs);
    tests++;
    if (d[2] !== 1'b0) begin
      fails++; $display("FAIL chen_clear: status=%h, required bit2=0", d);
    end
  endtask

  task automatic test_errors;
    logic [31:0] d;
    logic [1:0]  rs;
    bus_xfer(1'b1, W_BYTE, 8'h04, 32'd7, d, rs);
    tests++;
    if (rs !== R_ER || d !== 32'd0) begin
      fails++; $display("FAIL err_byte: resp=%0d rdata=%h, required resp 2 rdata 0", rs, d);
    end
    bus_xfer(1'b1, W_WORD, 8'h02, 32'd0, d, rs);
    tests++;
    if (rs !== R_ER) begin
      fails++; $display("FAIL err_misalign: resp=%0d, required 2", rs);
    end
    bus_xfer(1'b1, W_WORD, 8'h60, 32'd5, d, rs);
    tests++;
    if (rs !== R_ER) begin
      fails++; $display("FAIL err_ch_range: resp=%0d, required 2", rs);
    end
    rd(8'h60, d, rs);
    tests++;
    if (rs !== R_ER || d !== 32'd0) begin
      fails++; $display("FAIL err_ch_read: resp=%0d rdata=%h, required resp 2 rdata 0", rs, d);
    end
    rd(8'h04, d, rs);
    tests++;
    if (d !== 32'd3) begin
      fails++; $display("FAIL err_div_intact: divider=%0d, required 3", d);
    end
    rd(8'h00, d, rs);
    tests++;
    if (d !== 32'd1) begin
      fails++; $display("FAIL err_ctrl_intact: control=%0d, required 1", d);
    end
  endtask

  task automatic test_snapshot;
    logic [31:0] d;
    logic [31:0] exp_hi;
    logic [1:0]  rs;
`ifdef YCR1_MTIMER_SNAPSHOT_EN
    exp_hi = 32'd0;
`else
    exp_hi = 32'd1;
`endif
    wr(8'h00, 32'd0);
    wr(8'h04, 32'd0);
    wr(8'h08, 32'hFFFF_FFFF);
    wr(8'h0C, 32'd0);
    rd(8'h08, d, rs);
    tests++;
    if (d !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL snap_lo: data=%h, required ffffffff", d);
    end
    wr(8'h00, 32'd1);
    rd(8'h0C, d, rs);
    tests++;
    if (d !== exp_hi) begin
      fails++; $display("FAIL snap_hi: data=%h, required %h", d, exp_hi);
    end
  endtask

  task automatic test_back_to_back;
    logic exp_ack;
    @(negedge clk);
    dmem_req   = 1'b1;
    dmem_cmd   = 1'b0;
    dmem_width = W_WORD;
    dmem_addr  = 8'h04;
    for (int k = 0; k < 6; k++) begin
      step(1);
      exp_ack = (k % 2 == 0);
      tests++;
      if (dmem_req_ack !== exp_ack) begin
        fails++; $display("FAIL b2b_ack[%0d]: ack=%b, required %b", k, dmem_req_ack, exp_ack);
      end
      if (!exp_ack) begin
        tests++;
        if (dmem_resp !== R_OK || dmem_rdata !== 32'd0) begin
          fails++; $display("FAIL b2b_resp[%0d]: resp=%0d rdata=%h, required 1 / 0", k, dmem_resp, dmem_rdata);
        end
      end
      $display("[TB] b2b cycle %0d ack=%b resp=%0d", k, dmem_req_ack, dmem_resp);
    end
    dmem_req = 1'b0;
    step(3);
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    dmem_req  = 1'b1;
    dmem_cmd  = 1'b0;
    dmem_addr = 8'h00;
    step(1);
    rst      = 1'b1;
    dmem_req = 1'b0;
    step(1);
    tests++;
    if (dmem_req_ack !== 1'b0 || dmem_resp !== R_NOTRDY || timer_val !== 64'd0) begin
      fails++; $display("FAIL rst_mid_access: ack=%b resp=%0d mtime=%h, required 0 0 0", dmem_req_ack, dmem_resp, timer_val);
    end
    rst = 1'b0;
    step(1);
    tests++;
    if (dmem_req_ack !== 1'b0 || dmem_resp !== R_NOTRDY) begin
      fails++; $display("FAIL rst_no_resp: ack=%b resp=%0d, required 0 0", dmem_req_ack, dmem_resp);
    end
  endtask

  initial begin
    test_reset;
    test_prescaler;
    test_carry;
    test_periodic;
    test_level;
    test_set_wins;
    test_errors;
    test_snapshot;
    test_back_to_back;
    test_reset_mid_access;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
